// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target and the companion controller:
// FSM state encoding, default target address and the read/write bit value.
package i2c_pkg;

   localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h04;
   localparam logic       I2C_RW_READ      = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ADDR_ACK  = 3'd2,
      ST_RX_DATA   = 3'd3,
      ST_RX_ACK    = 3'd4,
      ST_TX_DATA   = 3'd5,
      ST_TX_ACK    = 3'd6,
      ST_WAIT_STOP = 3'd7
   } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer plus one-flop edge detector for an I2C line.
// Ports: clk, rst (async high), din (raw line) -> level, rise, fall.
module i2c_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync;
   logic              prev;

   // Reset to 1: an idle I2C bus floats high, so no edge is seen
   // when reset releases on a quiet bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '1;
         prev <= 1'b1;
      end else begin
         sync <= {sync[STAGES-2:0], din};
         prev <= sync[STAGES-1];
      end
   end

   assign level = sync[STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/i2c_target_slave.sv
// Single-byte I2C target: answers SLAVE_ADDR, receives or returns one byte.
// Ports: HCLK, HRESET, scl, sda_in, sda_oe (open-drain pull-low),
//        rx_data/rx_valid, tx_data/tx_taken, busy.
module i2c_target_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = I2C_DEFAULT_ADDR,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_taken,
   output logic       busy
);

   logic   scl_lvl;
   logic   scl_rise;
   logic   scl_fall;
   logic   sda_lvl;
   logic   sda_rise;
   logic   sda_fall;
   logic   start;
   logic   stop;

   state_t     state;
   logic [2:0] cnt;
   logic [7:0] shreg;
   logic [7:0] txsh;
   logic       rw;

   i2c_sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_scl (
      .clk   (HCLK),
      .rst   (HRESET),
      .din   (scl),
      .level (scl_lvl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_sda (
      .clk   (HCLK),
      .rst   (HRESET),
      .din   (sda_in),
      .level (sda_lvl),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   assign start = sda_fall & scl_lvl;
   assign stop  = sda_rise & scl_lvl;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state    <= ST_IDLE;
         cnt      <= 3'd0;
         shreg    <= 8'h00;
         txsh     <= 8'h00;
         rw       <= 1'b0;
         sda_oe   <= 1'b0;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         tx_taken <= 1'b0;
         busy     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         tx_taken <= 1'b0;
         // Bus conditions outrank any scl edge seen in the same cycle.
         if (stop) begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else if (start) begin
            state  <= ST_ADDR;
            cnt    <= 3'd7;
            sda_oe <= 1'b0;
            busy   <= 1'b1;
         end else begin
            unique case (state)
               ST_ADDR: begin
                  if (scl_rise) begin
                     shreg <= {shreg[6:0], sda_lvl};
                     if (cnt == 3'd0) begin
                        // shreg[6:0] already holds the 7 address bits;
                        // the bit arriving now is R/W.
                        rw <= sda_lvl;
                        if (shreg[6:0] == SLAVE_ADDR) begin
                           state <= ST_ADDR_ACK;
                        end else begin
                           state <= ST_WAIT_STOP;
                        end
                     end else begin
                        cnt <= cnt - 3'd1;
                     end
                  end
               end
               ST_ADDR_ACK: begin
                  // First fall starts the ACK low, second fall ends it.
                  if (scl_fall) begin
                     if (!sda_oe) begin
                        sda_oe <= 1'b1;
                     end else begin
                        cnt <= 3'd7;
                        if (rw == I2C_RW_READ) begin
                           // The ACK-ending fall is also where the
                           // MSB of the read byte goes on the wire.
                           state    <= ST_TX_DATA;
                           tx_taken <= 1'b1;
                           sda_oe   <= ~tx_data[7];
                           txsh     <= {tx_data[6:0], 1'b0};
                        end else begin
                           state  <= ST_RX_DATA;
                           sda_oe <= 1'b0;
                        end
                     end
                  end
               end
               ST_TX_DATA: begin
                  if (scl_rise) begin
                     if (cnt == 3'd0) begin
                        state <= ST_TX_ACK;
                     end else begin
                        cnt <= cnt - 3'd1;
                     end
                  end else if (scl_fall) begin
                     sda_oe <= ~txsh[7];
                     txsh   <= {txsh[6:0], 1'b0};
                  end
               end
               ST_TX_ACK: begin
                  // Release after bit 0, then take the master's ACK or
                  // NACK; only one byte is served either way.
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                  end else if (scl_rise) begin
                     state <= ST_WAIT_STOP;
                  end
               end
               ST_RX_DATA: begin
                  if (scl_rise) begin
                     shreg <= {shreg[6:0], sda_lvl};
                     if (cnt == 3'd0) begin
                        state <= ST_RX_ACK;
                     end else begin
                        cnt <= cnt - 3'd1;
                     end
                  end
               end
               ST_RX_ACK: begin
                  if (scl_fall) begin
                     if (!sda_oe) begin
                        sda_oe   <= 1'b1;
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= ST_WAIT_STOP;
                     end
                  end
               end
               default: begin
                  // IDLE and WAIT_STOP only leave on START or STOP.
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_slave.sv
// Directed bench for i2c_target_slave: a bit-banged master drives the bus
// with 8 HCLK per scl half-period, open-drain modelled as a wired AND.
module tb_i2c_target_slave;
   import i2c_pkg::*;

   logic       HCLK = 1'b0;
   logic       HRESET = 1'b1;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data = 8'h00;
   logic       tx_taken;
   logic       busy;

   int total = 0;
   int bad = 0;
   int rv_cnt = 0;
   int tt_cnt = 0;
   int oe_cnt = 0;

   assign sda_in = sda_m & ~sda_oe;

   i2c_target_slave dut (
      .HCLK     (HCLK),
      .HRESET   (HRESET),
      .scl      (scl),
      .sda_in   (sda_in),
      .sda_oe   (sda_oe),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_taken (tx_taken),
      .busy     (busy)
   );

   always #5 HCLK = ~HCLK;

   always @(posedge HCLK) begin
      if (rx_valid) rv_cnt <= rv_cnt + 1;
      if (tx_taken) tt_cnt <= tt_cnt + 1;
      if (sda_oe)   oe_cnt <= oe_cnt + 1;
   end

   task automatic wclk(input int n);
      repeat (n) @(negedge HCLK);
   endtask

   task automatic m_start();
      sda_m = 1'b1; wclk(4);
      scl = 1'b1;   wclk(8);
      sda_m = 1'b0; wclk(8);
      scl = 1'b0;   wclk(4);
   endtask

   task automatic m_stop();
      sda_m = 1'b0; wclk(4);
      scl = 1'b1;   wclk(8);
      sda_m = 1'b1; wclk(8);
   endtask

   task automatic m_wbit(input logic b);
      sda_m = b; wclk(4);
      scl = 1'b1; wclk(8);
      scl = 1'b0; wclk(4);
   endtask

   task automatic m_rbit(output logic b);
      sda_m = 1'b1; wclk(4);
      scl = 1'b1;   wclk(4);
      b = sda_in;   wclk(4);
      scl = 1'b0;   wclk(4);
   endtask

   task automatic m_wbyte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) m_wbit(d[i]);
      m_rbit(ack);
   endtask

   task automatic m_rbyte(output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         m_rbit(b);
         d[i] = b;
      end
   endtask

   task automatic test_reset();
      wclk(3);
      HRESET = 1'b0;
      wclk(3);
      total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rst_oe got=%b exp=0", sda_oe); end
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_rx got=%h exp=00", rx_data); end
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rv got=%b exp=0", rx_valid); end
      total++; if (tx_taken !== 1'b0) begin bad++; $display("FAIL rst_tt got=%b exp=0", tx_taken); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dut.state, ST_IDLE); end
   endtask

   task automatic test_write();
      logic ack;
      int rv0;
      rv0 = rv_cnt;
      m_start();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", busy); end
      m_wbyte(8'h08, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL wr_addr_ack got=%b exp=0", ack); end
      m_wbyte(8'hA5, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL wr_data_ack got=%b exp=0", ack); end
      m_stop();
      wclk(4);
      total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL wr_rx got=%h exp=a5", rx_data); end
      total++; if (rv_cnt - rv0 !== 1) begin bad++; $display("FAIL wr_rv_cnt got=%0d exp=1", rv_cnt - rv0); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_end got=%b exp=0", busy); end
      total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL wr_state got=%0d exp=%0d", dut.state, ST_IDLE); end
   endtask

   task automatic test_read();
      logic ack;
      logic [7:0] d;
      int tt0;
      tt0 = tt_cnt;
      tx_data = 8'h3C;
      m_start();
      m_wbyte(8'h09, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL rd_addr_ack got=%b exp=0", ack); end
      m_rbyte(d);
      total++; if (d !== 8'h3C) begin bad++; $display("FAIL rd_bits got=%h exp=3c", d); end
      total++; if (tt_cnt - tt0 !== 1) begin bad++; $display("FAIL rd_tt_cnt got=%0d exp=1", tt_cnt - tt0); end
      m_wbit(1'b1);
      wclk(2);
      total++; if (dut.state !== ST_WAIT_STOP) begin bad++; $display("FAIL rd_nack_state got=%0d exp=%0d", dut.state, ST_WAIT_STOP); end
      total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rd_oe_rel got=%b exp=0", sda_oe); end
      m_stop();
      wclk(4);
      total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL rd_state got=%0d exp=%0d", dut.state, ST_IDLE); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy got=%b exp=0", busy); end
   endtask

   task automatic test_bad_addr();
      logic ack;
      int oe0;
      int rv0;
      oe0 = oe_cnt;
      rv0 = rv_cnt;
      m_start();
      m_wbyte(8'h0A, ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL ba_ack got=%b exp=1", ack); end
      total++; if (dut.state !== ST_WAIT_STOP) begin bad++; $display("FAIL ba_state got=%0d exp=%0d", dut.state, ST_WAIT_STOP); end
      m_wbyte(8'hFF, ack);
      total++; if (dut.state !== ST_WAIT_STOP) begin bad++; $display("FAIL ba_state2 got=%0d exp=%0d", dut.state, ST_WAIT_STOP); end
      m_stop();
      wclk(4);
      total++; if (oe_cnt - oe0 !== 0) begin bad++; $display("FAIL ba_oe got=%0d exp=0", oe_cnt - oe0); end
      total++; if (rv_cnt - rv0 !== 0) begin bad++; $display("FAIL ba_rv got=%0d exp=0", rv_cnt - rv0); end
      total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL ba_idle got=%0d exp=%0d", dut.state, ST_IDLE); end
   endtask

   task automatic test_repeated_start();
      logic ack;
      int rv0;
      rv0 = rv_cnt;
      m_start();
      m_wbyte(8'h08, ack);
      m_wbit(1'b1);
      m_wbit(1'b0);
      m_wbit(1'b1);
      m_start();
      total++; if (dut.state !== ST_ADDR) begin bad++; $display("FAIL rs_state got=%0d exp=%0d", dut.state, ST_ADDR); end
      total++; if (rv_cnt - rv0 !== 0) begin bad++; $display("FAIL rs_rv got=%0d exp=0", rv_cnt - rv0); end
      m_wbyte(8'h08, ack);
      m_wbyte(8'h11, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL rs_ack got=%b exp=0", ack); end
      m_stop();
      wclk(4);
      total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL rs_rx got=%h exp=11", rx_data); end
      total++; if (rv_cnt - rv0 !== 1) begin bad++; $display("FAIL rs_rv_end got=%0d exp=1", rv_cnt - rv0); end
   endtask

   task automatic test_reset_mid_tx();
      logic ack;
      tx_data = 8'h3C;
      m_start();
      m_wbyte(8'h09, ack);
      wclk(2);
      total++; if (dut.state !== ST_TX_DATA) begin bad++; $display("FAIL rt_state got=%0d exp=%0d", dut.state, ST_TX_DATA); end
      total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL rt_oe_pre got=%b exp=1", sda_oe); end
      HRESET = 1'b1;
      #1;
      total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rt_oe_async got=%b exp=0", sda_oe); end
      wclk(2);
      HRESET = 1'b0;
      wclk(2);
      total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL rt_idle got=%0d exp=%0d", dut.state, ST_IDLE); end
      m_stop();
      m_start();
      m_wbyte(8'h08, ack);
      m_wbyte(8'h5A, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL rt_ack got=%b exp=0", ack); end
      m_stop();
      wclk(4);
      total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL rt_rx got=%h exp=5a", rx_data); end
   endtask

   task automatic test_stop_mid_rx();
      logic ack;
      int rv0;
      rv0 = rv_cnt;
      m_start();
      m_wbyte(8'h08, ack);
      m_wbit(1'b1);
      m_wbit(1'b1);
      m_wbit(1'b0);
      m_wbit(1'b0);
      total++; if (dut.state !== ST_RX_DATA) begin bad++; $display("FAIL sp_rx_state got=%0d exp=%0d", dut.state, ST_RX_DATA); end
      m_stop();
      wclk(4);
      total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL sp_state got=%0d exp=%0d", dut.state, ST_IDLE); end
      total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL sp_rx got=%h exp=5a", rx_data); end
      total++; if (rv_cnt - rv0 !== 0) begin bad++; $display("FAIL sp_rv got=%0d exp=0", rv_cnt - rv0); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL sp_busy got=%b exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_bad_addr();
      test_repeated_start();
      test_reset_mid_tx();
      test_stop_mid_rx();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_target_slave.md
I2C_TARGET_SLAVE -- requirements
Module: i2c_target_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h04; 7-bit bus address this target answers to.
REQ-002 Parameter SYNC_STAGES, default 2; synchronizer depth on scl and sda, minimum 2.
REQ-003 HCLK  input  1  system clock.
REQ-004 HRESET  input  1  reset, asynchronous, active-high.
REQ-005 Clock and reset are decided: one clock (HCLK); HRESET is asynchronous and active-high.
REQ-006 scl  input  1  I2C clock from the bus master, asynchronous to HCLK.
REQ-007 sda_in  input  1  sampled level of the shared sda line.
REQ-008 sda_oe  output  1  1 = pull sda low (open-drain); 0 = release the line.
REQ-009 rx_data  output  8  last byte written by the master.
REQ-010 rx_valid  output  1  one-HCLK pulse when rx_data is updated.
REQ-011 tx_data  input  8  byte returned to the master on a read.
REQ-012 tx_taken  output  1  one-HCLK pulse when tx_data is latched into the shift register.
REQ-013 busy  output  1  high from detected START to detected STOP.

Function
REQ-014 scl and sda_in shall each pass through SYNC_STAGES flops, then a one-flop edge detector; decisions use only synchronized values.
REQ-015 START is sda falling while scl is high; STOP is sda rising while scl is high.
REQ-016 Bits shall be sampled on the synchronized scl rising edge, MSB first.
REQ-017 sda_oe shall change only on a synchronized scl falling edge, or on STOP, or on reset.
REQ-018 FSM states: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
REQ-019 IDLE->ADDR on START; the bit counter loads 7.
REQ-020 ADDR shifts 8 bits ({addr[6:0], rw}); after the 8th bit it goes to ADDR_ACK if addr==SLAVE_ADDR, else to WAIT_STOP with sda_oe held at 0.
REQ-021 ADDR_ACK: sda_oe=1 from the following scl fall to the next scl fall; then RX_DATA if rw==0, or TX_DATA if rw==1.
REQ-022 On entering TX_DATA, tx_data shall be latched and tx_taken pulsed.
REQ-023 TX_DATA: at each scl fall, sda_oe = ~bit, MSB first; after 8 bits, TX_ACK.
REQ-024 TX_ACK: sda_oe=0; sample the master bit on scl rise; then WAIT_STOP for both ACK and NACK (one byte per transaction).
REQ-025 RX_DATA: shift 8 bits, then RX_ACK.
REQ-026 RX_ACK: drive the ACK exactly as in REQ-021; rx_data updates and rx_valid pulses in the HCLK cycle of the ACK scl fall.
REQ-027 RX_ACK and TX_ACK both proceed to WAIT_STOP.
REQ-028 STOP in any state: go to IDLE, sda_oe=0, busy=0 in the next HCLK cycle.
REQ-029 START in any non-IDLE state (repeated start): go to ADDR, sda_oe=0, counter reloaded to 7.
REQ-030 If START/STOP and an scl edge are detected in the same cycle, START/STOP wins.
REQ-031 Correct operation requires every scl/sda level to be stable for at least SYNC_STAGES+2 HCLK cycles; the companion controller (4 HCLK per scl half-period) meets this with SYNC_STAGES=2.
REQ-032 The block shall never drive sda high.

Reset
REQ-033 HRESET high: state=IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_taken=0, busy=0, counter=0, synchronizers=1 (bus idle high).
REQ-034 Reset mid-transfer shall release sda immediately (asynchronously) and ignore the bus until the next START.

Structure
REQ-035 Shared package i2c_pkg shall hold the state enum, the default slave address 7'h04, and the constant I2C_RW_READ=1'b1; the controller shall use the same package.
REQ-036 One sub-module, i2c_sync_edge (synchronizer plus rise/fall/level outputs), instantiated once for scl and once for sda.

Verification
REQ-037 Write 0xA5 to 0x04 (address byte 0x08) -> ACK driven on both the address and data bits, rx_data=0xA5, exactly one rx_valid pulse, busy returns to 0 after STOP.
REQ-038 Read from 0x04 with tx_data=0x3C (address byte 0x09) -> one tx_taken pulse; bus bits 0,0,1,1,1,1,0,0; master NACK -> WAIT_STOP -> IDLE.
REQ-039 Address byte 0x0A (address 0x05) -> sda_oe never asserts, no rx_valid, state WAIT_STOP until STOP.
REQ-040 Repeated START after 3 data bits of a write -> state ADDR, no rx_valid; the following full write of 0x11 gives rx_data=0x11.
REQ-041 HRESET pulse during TX_DATA while sda_oe=1 -> sda_oe=0 in the same cycle; subsequent valid write of 0x5A succeeds.
REQ-042 STOP injected mid RX_DATA -> IDLE, rx_data unchanged, no rx_valid pulse.
